enc8x3_seq: RTL

Sequential 8-to-3 priority encoder that serves a captured 8-bit request word one index at a time. It latches a request vector, presents the highest-numbered pending bit as a 3-bit code with a valid/ack handshake, and clears each bit once it is acknowledged. It is the encoding counterpart of the lab's 3-to-8 decoder logic, so its output code can feed a dec3x8 directly.

---
 rtl/enc8x3_seq.sv | 85 ++++++++
 1 files changed

// File: rtl/enc8x3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request word and hands out the
// index of each set bit, highest first, through a registered valid/ack handshake.
module enc8x3_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] D,
    input  logic       load,
    input  logic       ack,
    output logic [2:0] Y,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       none,
    output logic [7:0] pending,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0] state;
    logic [2:0] hi_idx;
    logic [7:0] pending_after_ack;

    // Ascending walk: the last set bit seen is the highest one.
    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) hi_idx = i[2:0];
        end
    end

    assign pending_after_ack = pending & ~(8'h01 << Y);

    // Handshake: Y is presented with valid=1 and held unchanged until the edge
    // that samples ack=1 while valid=1; ack at any other time has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            Y       <= 3'b000;
            valid   <= 1'b0;
            done    <= 1'b0;
            none    <= 1'b0;
            pending <= 8'h00;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (D != 8'h00) begin
                            pending <= D;
                            state   <= SCAN;
                        end else begin
                            none <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    Y     <= hi_idx;
                    valid <= 1'b1;
                    state <= PRESENT;
                end
                PRESENT: begin
                    if (ack && valid) begin
                        pending <= pending_after_ack;
                        valid   <= 1'b0;
                        if (pending_after_ack != 8'h00) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
